alu_power_sequencer: RTL and testbench

//  Downstream of the ALU power-gating controller. Consumes its power_enable request and drives
//  the physical ALU power-domain controls in order: clock gate, isolation, retention, power switch.

---
 rtl/alu_pwr_pkg.sv | 63 ++++++
 rtl/alu_power_sequencer_timer.sv | 33 +++
 rtl/alu_power_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_power_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pwr_pkg.sv
// Shared definitions for the ALU power-domain sequencer: state encodings,
// default timing constants and the per-state control decode.
package alu_pwr_pkg;

    localparam int ISO_CYC_DEF  = 2;
    localparam int SAVE_CYC_DEF = 2;
    localparam int RSTR_CYC_DEF = 2;
    localparam int ACK_TO_DEF   = 15;
    localparam int CNT_W_DEF    = 16;

    typedef enum logic [2:0] {
        ST_ON    = 3'd0,
        ST_ISO   = 3'd1,
        ST_SAVE  = 3'd2,
        ST_SWOFF = 3'd3,
        ST_OFF   = 3'd4,
        ST_SWON  = 3'd5,
        ST_RSTR  = 3'd6,
        ST_UNISO = 3'd7
    } pwr_state_e;

    typedef struct packed {
        logic clk_en;
        logic iso;
        logic save;
        logic restore;
        logic sw;
        logic ready;
    } pwr_ctrl_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Physical domain controls that must be presented while in state s.
    function automatic pwr_ctrl_t decode_ctrl(input pwr_state_e s);
        pwr_ctrl_t c;
        c    = '0;
        c.sw = 1'b1;
        case (s)
            ST_ON: begin
                c.clk_en = 1'b1;
                c.ready  = 1'b1;
            end
            ST_ISO, ST_UNISO, ST_SWON: c.iso = 1'b1;
            ST_SAVE: begin
                c.iso  = 1'b1;
                c.save = 1'b1;
            end
            ST_SWOFF, ST_OFF: begin
                c.iso = 1'b1;
                c.sw  = 1'b0;
            end
            ST_RSTR: begin
                c.iso     = 1'b1;
                c.restore = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_power_sequencer_timer.sv
// Shared phase counter: cleared on state entry, counts cycles spent in the
// current state and saturates at SAT so long ack waits never wrap.
module pwr_wait_timer #(
    parameter int W   = 5,
    parameter int SAT = 15
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_clear,
    input  logic [W-1:0] i_target,
    output logic         o_done,
    output logic         o_timeout
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt != W'(SAT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A target of N means the state is held for exactly N cycles.
    assign o_done    = (r_cnt >= (i_target - 1'b1));
    assign o_timeout = (r_cnt >= W'(SAT - 1));

endmodule

// File: rtl/alu_power_sequencer.sv
// ALU power-domain sequencer: orders clock gate, isolation, retention and
// power switch on gate/wake requests, watches power-good, keeps residency stats.
module alu_power_sequencer
    import alu_pwr_pkg::*;
#(
    parameter int ISO_CYC  = ISO_CYC_DEF,
    parameter int SAVE_CYC = SAVE_CYC_DEF,
    parameter int RSTR_CYC = RSTR_CYC_DEF,
    parameter int ACK_TO   = ACK_TO_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             power_enable,
    input  logic             pwr_ack,
    output logic             alu_clk_en,
    output logic             iso_en,
    output logic             ret_save,
    output logic             ret_restore,
    output logic             pwr_sw_en,
    output logic             domain_ready,
    output logic             pwr_fault,
    output logic [CNT_W-1:0] off_cycles,
    output logic [CNT_W-1:0] wake_count
);

    localparam int MAX_CYC = max_of(max_of(ISO_CYC, SAVE_CYC), max_of(RSTR_CYC, ACK_TO));
    localparam int TMR_W   = $clog2(MAX_CYC) + 1;

    pwr_state_e       r_state;
    pwr_state_e       w_next;
    pwr_ctrl_t        r_ctrl;
    pwr_ctrl_t        w_ctrl;
    logic             r_fault;
    logic             r_from_rstr;
    logic [CNT_W-1:0] r_off;
    logic [CNT_W-1:0] r_wake;
    logic [TMR_W-1:0] w_target;
    logic             w_done;
    logic             w_timeout;
    logic             w_fault_set;
    logic             w_clear;

    pwr_wait_timer #(
        .W   (TMR_W),
        .SAT (ACK_TO)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_clear),
        .i_target  (w_target),
        .o_done    (w_done),
        .o_timeout (w_timeout)
    );

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next      = r_state;
        w_fault_set = 1'b0;
        w_target    = TMR_W'(ACK_TO);
        case (r_state)
            ST_ON: begin
                if (!power_enable) w_next = ST_ISO;
            end
            ST_ISO: begin
                w_target = TMR_W'(ISO_CYC);
                if (power_enable) w_next = ST_UNISO;
                else if (w_done)  w_next = ST_SAVE;
            end
            ST_SAVE: begin
                w_target = TMR_W'(SAVE_CYC);
                if (w_done) w_next = ST_SWOFF;
            end
            ST_SWOFF: begin
                if (!pwr_ack) begin
                    w_next = ST_OFF;
                end else if (w_timeout) begin
                    w_fault_set = 1'b1;
                    w_next      = ST_OFF;
                end
            end
            ST_OFF: begin
                if (power_enable) w_next = ST_SWON;
            end
            ST_SWON: begin
                // A missing power-good is flagged but the wait continues.
                if (pwr_ack)        w_next = ST_RSTR;
                else if (w_timeout) w_fault_set = 1'b1;
            end
            ST_RSTR: begin
                w_target = TMR_W'(RSTR_CYC);
                if (w_done) w_next = ST_UNISO;
            end
            ST_UNISO: begin
                w_target = TMR_W'(ISO_CYC);
                if (w_done) w_next = ST_ON;
            end
            default: w_next = ST_ON;
        endcase
    end

    assign w_clear = (w_next != r_state);
    assign w_ctrl  = decode_ctrl(w_next);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_ON;
            r_ctrl      <= decode_ctrl(ST_ON);
            r_fault     <= 1'b0;
            r_from_rstr <= 1'b0;
            r_off       <= '0;
            r_wake      <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= w_ctrl;
            r_fault <= r_fault | w_fault_set;
            if (r_state == ST_OFF && r_off != '1) begin
                r_off <= r_off + 1'b1;
            end
            // Remember whether UNISO was reached through a real power-up.
            if (w_next == ST_UNISO && w_clear) begin
                r_from_rstr <= (r_state == ST_RSTR);
            end
            if (r_state == ST_UNISO && w_next == ST_ON && r_from_rstr && r_wake != '1) begin
                r_wake <= r_wake + 1'b1;
            end
        end
    end

    assign alu_clk_en   = r_ctrl.clk_en;
    assign iso_en       = r_ctrl.iso;
    assign ret_save     = r_ctrl.save;
    assign ret_restore  = r_ctrl.restore;
    assign pwr_sw_en    = r_ctrl.sw;
    assign domain_ready = r_ctrl.ready;
    assign pwr_fault    = r_fault;
    assign off_cycles   = r_off;
    assign wake_count   = r_wake;

endmodule

// File: tb/tb_alu_power_sequencer.sv
// Directed bench for alu_power_sequencer: per-cycle vector table for the
// normal, abort and wake-in-SAVE sequences, hand-written timeout and reset cases.
module tb_alu_power_sequencer;

    logic        clk;
    logic        reset_n;
    logic        power_enable;
    logic        pwr_ack;
    logic        alu_clk_en;
    logic        iso_en;
    logic        ret_save;
    logic        ret_restore;
    logic        pwr_sw_en;
    logic        domain_ready;
    logic        pwr_fault;
    logic [15:0] off_cycles;
    logic [15:0] wake_count;

    // Output bundle {clk_en, iso, save, restore, sw, ready, fault}.
    localparam logic [6:0] O_ON   = 7'b1000110;
    localparam logic [6:0] O_ISO  = 7'b0100100;
    localparam logic [6:0] O_SAVE = 7'b0110100;
    localparam logic [6:0] O_OFF  = 7'b0100000;
    localparam logic [6:0] O_RSTR = 7'b0101100;
    localparam logic [6:0] O_FLT  = 7'b0000001;

    typedef struct {
        logic       pe;
        logic       ack;
        logic [6:0] exp_ctrl;
        int         exp_off;
        int         exp_wake;
        string      tag;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_err;

    alu_power_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .power_enable (power_enable),
        .pwr_ack      (pwr_ack),
        .alu_clk_en   (alu_clk_en),
        .iso_en       (iso_en),
        .ret_save     (ret_save),
        .ret_restore  (ret_restore),
        .pwr_sw_en    (pwr_sw_en),
        .domain_ready (domain_ready),
        .pwr_fault    (pwr_fault),
        .off_cycles   (off_cycles),
        .wake_count   (wake_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] obs();
        return {alu_clk_en, iso_en, ret_save, ret_restore, pwr_sw_en, domain_ready, pwr_fault};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic pe, input logic ack);
        power_enable = pe;
        pwr_ack      = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic pe, input logic ack, input logic [6:0] e,
                       input int off, input int wake, input string tag);
        vec_t v;
        v.pe = pe; v.ack = ack; v.exp_ctrl = e;
        v.exp_off = off; v.exp_wake = wake; v.tag = tag;
        vecs.push_back(v);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        reset_n      = 1'b0;
        power_enable = 1'b1;
        pwr_ack      = 1'b1;

        // Steady ON, ack wiggle ignored outside SWOFF/SWON.
        add(1, 1, O_ON, 0, 0, "on_hold0");
        add(1, 0, O_ON, 0, 0, "on_ack_ignored");
        add(1, 1, O_ON, 0, 0, "on_hold1");
        // Abort: one-cycle gate request.
        add(0, 1, O_ISO, 0, 0, "abort_iso");
        add(1, 1, O_ISO, 0, 0, "abort_uniso0");
        add(1, 1, O_ISO, 0, 0, "abort_uniso1");
        add(1, 1, O_ON,  0, 0, "abort_on");
        add(1, 1, O_ON,  0, 0, "abort_on_hold");
        // Full power-down / power-up with ack responding after 3 cycles.
        add(0, 1, O_ISO,  0, 0, "full_iso0");
        add(0, 1, O_ISO,  0, 0, "full_iso1");
        add(0, 1, O_SAVE, 0, 0, "full_save0");
        add(0, 1, O_SAVE, 0, 0, "full_save1");
        add(0, 1, O_OFF,  0, 0, "full_swoff0");
        add(0, 1, O_OFF,  0, 0, "full_swoff1");
        add(0, 1, O_OFF,  0, 0, "full_swoff2");
        add(0, 0, O_OFF,  0, 0, "full_off0");
        add(0, 0, O_OFF,  1, 0, "full_off1");
        add(0, 0, O_OFF,  2, 0, "full_off2");
        add(0, 0, O_OFF,  3, 0, "full_off3");
        add(1, 0, O_ISO,  4, 0, "full_swon0");
        add(0, 0, O_ISO,  4, 0, "full_swon_pe_ignored");
        add(1, 1, O_RSTR, 4, 0, "full_rstr0");
        add(0, 1, O_RSTR, 4, 0, "full_rstr_pe_ignored");
        add(1, 1, O_ISO,  4, 0, "full_uniso0");
        add(1, 1, O_ISO,  4, 0, "full_uniso1");
        add(1, 1, O_ON,   4, 1, "full_on");
        // Wake request arriving during SAVE.
        add(0, 1, O_ISO,  4, 1, "wsave_iso0");
        add(0, 1, O_ISO,  4, 1, "wsave_iso1");
        add(0, 1, O_SAVE, 4, 1, "wsave_save0");
        add(1, 1, O_SAVE, 4, 1, "wsave_save1");
        add(1, 1, O_OFF,  4, 1, "wsave_swoff");
        add(1, 0, O_OFF,  4, 1, "wsave_off");
        add(1, 0, O_ISO,  5, 1, "wsave_swon");
        add(1, 1, O_RSTR, 5, 1, "wsave_rstr0");
        add(1, 1, O_RSTR, 5, 1, "wsave_rstr1");
        add(1, 1, O_ISO,  5, 1, "wsave_uniso0");
        add(1, 1, O_ISO,  5, 1, "wsave_uniso1");
        add(1, 1, O_ON,   5, 2, "wsave_on");

        #12;
        check("reset_ctrl", 32'(obs()), 32'(O_ON));
        check("reset_off", 32'(off_cycles), 0);
        check("reset_wake", 32'(wake_count), 0);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].pe, vecs[i].ack);
            check({vecs[i].tag, "_ctrl"}, 32'(obs()), 32'(vecs[i].exp_ctrl));
            check({vecs[i].tag, "_off"}, 32'(off_cycles), 32'(vecs[i].exp_off));
            check({vecs[i].tag, "_wake"}, 32'(wake_count), 32'(vecs[i].exp_wake));
        end

        // Ack stuck high in SWOFF: 15 cycles then fault and OFF.
        step(0, 1);
        check("to_iso", 32'(obs()), 32'(O_ISO));
        step(0, 1);
        step(0, 1);
        step(0, 1);
        step(0, 1);
        check("to_swoff_entry", 32'(obs()), 32'(O_OFF));
        for (int k = 1; k < 15; k++) begin
            step(0, 1);
            check($sformatf("to_swoff_wait%0d", k), 32'(obs()), 32'(O_OFF));
        end
        step(0, 1);
        check("to_swoff_fault", 32'(obs()), 32'(O_OFF | O_FLT));
        check("to_swoff_off_cnt", 32'(off_cycles), 5);
        step(1, 0);
        check("to_swon_entry", 32'(obs()), 32'(O_ISO | O_FLT));
        check("to_off_residency", 32'(off_cycles), 6);
        // Ack stuck low in SWON: stays put with fault held.
        for (int k = 0; k < 20; k++) begin
            step(1, 0);
            if (k % 5 == 4) check($sformatf("to_swon_hold%0d", k), 32'(obs()), 32'(O_ISO | O_FLT));
        end
        step(1, 1);
        check("to_rstr", 32'(obs()), 32'(O_RSTR | O_FLT));
        step(1, 1);
        step(1, 1);
        step(1, 1);
        check("to_uniso", 32'(obs()), 32'(O_ISO | O_FLT));
        step(1, 1);
        check("to_on", 32'(obs()), 32'(O_ON | O_FLT));
        check("to_wake", 32'(wake_count), 3);

        // Async reset while OFF forces the domain back on at once.
        for (int k = 0; k < 5; k++) step(0, 1);
        step(0, 0);
        step(0, 0);
        check("rst_pre_off", 32'(obs()), 32'(O_OFF | O_FLT));
        check("rst_pre_cnt", 32'(off_cycles), 7);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_ctrl", 32'(obs()), 32'(O_ON));
        check("rst_async_off", 32'(off_cycles), 0);
        check("rst_async_wake", 32'(wake_count), 0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        step(1, 1);
        check("rst_after_on", 32'(obs()), 32'(O_ON));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
